// File: rtl/uart_tx_stream.sv
// UART transmitter with an input FIFO (valid/ready), internal s_tick divider and
// a frame FSM supporting 5..9 data bits, optional parity and 1/1.5/2 stop bits.
module uart_tx_stream #(
    parameter int CLK_DIV    = 326,
    parameter int DBIT       = 8,
    parameter int PARITY     = 0,
    parameter int SB_TICK    = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DBIT-1:0]               din,
    input  logic                          din_valid,
    output logic                          din_ready,
    output logic                          tx,
    output logic                          busy,
    output logic                          tx_done_tick,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(CLK_DIV);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] PAR   = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;

    logic [DBIT-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push;
    logic            pop;
    logic [2:0]      state;
    logic [DW-1:0]   div_cnt;
    logic            s_tick;
    logic [5:0]      tick_cnt;
    logic [3:0]      bit_cnt;
    logic [DBIT-1:0] shreg;
    logic            par_bit;
    logic            line;
    logic            bit_end;
    logic            stop_end;

    function automatic logic parity_of(input logic [DBIT-1:0] w);
        return (PARITY == 2) ? ~^w : ^w;
    endfunction

    assign din_ready    = (fifo_count != (PW+1)'(FIFO_DEPTH));
    assign push         = din_valid & din_ready;
    assign pop          = (state == IDLE) && (fifo_count != {(PW+1){1'b0}});
    assign s_tick       = (div_cnt == DW'(CLK_DIV - 1));
    assign bit_end      = s_tick && (tick_cnt == 6'd15);
    assign stop_end     = s_tick && (tick_cnt == 6'(SB_TICK - 1));
    // Done pulse coincides with the last stop s_tick rather than lagging it.
    assign tx_done_tick = (state == STOP) && stop_end;

    // FIFO storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= {PW{1'b0}};
            rd_ptr     <= {PW{1'b0}};
            fifo_count <= {(PW+1){1'b0}};
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (PW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // s_tick divider, re-phased on every pop so bit edges align to frame start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= {DW{1'b0}};
        end else if (pop || s_tick) begin
            div_cnt <= {DW{1'b0}};
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // Frame sequencer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            tick_cnt <= 6'd0;
            bit_cnt  <= 4'd0;
            shreg    <= {DBIT{1'b0}};
            par_bit  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg    <= mem[rd_ptr];
                        par_bit  <= parity_of(mem[rd_ptr]);
                        tick_cnt <= 6'd0;
                        bit_cnt  <= 4'd0;
                        state    <= START;
                        busy     <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tick_cnt <= 6'd0;
                        state    <= DATA;
                    end else if (s_tick) begin
                        tick_cnt <= tick_cnt + 6'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        tick_cnt <= 6'd0;
                        shreg    <= {1'b0, shreg[DBIT-1:1]};
                        if (bit_cnt == 4'(DBIT - 1)) begin
                            state <= (PARITY != 0) ? PAR : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else if (s_tick) begin
                        tick_cnt <= tick_cnt + 6'd1;
                    end
                end
                PAR: begin
                    if (bit_end) begin
                        tick_cnt <= 6'd0;
                        state    <= STOP;
                    end else if (s_tick) begin
                        tick_cnt <= tick_cnt + 6'd1;
                    end
                end
                STOP: begin
                    if (stop_end) begin
                        tick_cnt <= 6'd0;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end else if (s_tick) begin
                        tick_cnt <= tick_cnt + 6'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Line level selected by the current state
    always_comb begin
        line = 1'b1;
        case (state)
            START:   line = 1'b0;
            DATA:    line = shreg[0];
            PAR:     line = par_bit;
            default: line = 1'b1;
        endcase
    end

    // Registered serial output, forced idle-high by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx <= 1'b1;
        end else begin
            tx <= line;
        end
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed bench for uart_tx_stream: six instances cover parity modes, stop
// lengths and a 5-bit word; all run at CLK_DIV=4 (64 clk per bit).
`timescale 1ns/1ps
module tb_uart_tx_stream;

    logic       clk;
    logic       rst;
    logic [8:0] din_v [6];
    logic [5:0] valid_v;
    wire  [5:0] rdy_v;
    wire  [5:0] tx_v;
    wire  [5:0] busy_v;
    wire  [5:0] done_v;
    wire  [3:0] cnt_v [6];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_stream #(.CLK_DIV(4), .DBIT(8), .PARITY(0), .SB_TICK(16), .FIFO_DEPTH(8)) dut_a (
        .clk(clk), .rst(rst), .din(din_v[0][7:0]), .din_valid(valid_v[0]), .din_ready(rdy_v[0]),
        .tx(tx_v[0]), .busy(busy_v[0]), .tx_done_tick(done_v[0]), .fifo_count(cnt_v[0]));
    uart_tx_stream #(.CLK_DIV(4), .DBIT(8), .PARITY(1), .SB_TICK(16), .FIFO_DEPTH(8)) dut_e (
        .clk(clk), .rst(rst), .din(din_v[1][7:0]), .din_valid(valid_v[1]), .din_ready(rdy_v[1]),
        .tx(tx_v[1]), .busy(busy_v[1]), .tx_done_tick(done_v[1]), .fifo_count(cnt_v[1]));
    uart_tx_stream #(.CLK_DIV(4), .DBIT(8), .PARITY(2), .SB_TICK(16), .FIFO_DEPTH(8)) dut_o (
        .clk(clk), .rst(rst), .din(din_v[2][7:0]), .din_valid(valid_v[2]), .din_ready(rdy_v[2]),
        .tx(tx_v[2]), .busy(busy_v[2]), .tx_done_tick(done_v[2]), .fifo_count(cnt_v[2]));
    uart_tx_stream #(.CLK_DIV(4), .DBIT(8), .PARITY(0), .SB_TICK(32), .FIFO_DEPTH(8)) dut_s32 (
        .clk(clk), .rst(rst), .din(din_v[3][7:0]), .din_valid(valid_v[3]), .din_ready(rdy_v[3]),
        .tx(tx_v[3]), .busy(busy_v[3]), .tx_done_tick(done_v[3]), .fifo_count(cnt_v[3]));
    uart_tx_stream #(.CLK_DIV(4), .DBIT(8), .PARITY(0), .SB_TICK(24), .FIFO_DEPTH(8)) dut_s24 (
        .clk(clk), .rst(rst), .din(din_v[4][7:0]), .din_valid(valid_v[4]), .din_ready(rdy_v[4]),
        .tx(tx_v[4]), .busy(busy_v[4]), .tx_done_tick(done_v[4]), .fifo_count(cnt_v[4]));
    uart_tx_stream #(.CLK_DIV(4), .DBIT(5), .PARITY(0), .SB_TICK(16), .FIFO_DEPTH(8)) dut_d5 (
        .clk(clk), .rst(rst), .din(din_v[5][4:0]), .din_valid(valid_v[5]), .din_ready(rdy_v[5]),
        .tx(tx_v[5]), .busy(busy_v[5]), .tx_done_tick(done_v[5]), .fifo_count(cnt_v[5]));

    // Push one word into instance k (assumes ready); returns on the negedge after the push edge.
    task automatic push(input int k, input logic [8:0] d);
        din_v[k]   = d;
        valid_v[k] = 1'b1;
        @(negedge clk);
        valid_v[k] = 1'b0;
    endtask

    // Wait for the start bit, then check tx/busy/done on every clk of the frame.
    // Offset 0 is the first clk with tx=0; the state entered START one clk earlier,
    // so the last stop s_tick lands at offset nb*64 + sb*4 - 2.
    task automatic frame(input int k, input logic [8:0] data, input int dbit, input int has_par,
                         input logic par, input int sb, input int exp_gap, input string tag);
        logic [10:0] fb;
        logic        etx;
        logic        ebusy;
        logic        edone;
        int          nb;
        int          done_off;
        int          n;
        nb = 1 + dbit + has_par;
        fb = 11'd0;
        for (int i = 0; i < dbit; i++) fb[1+i] = data[i];
        if (has_par != 0) fb[1+dbit] = par;
        done_off = nb*64 + sb*4 - 2;
        n = 0;
        while (tx_v[k] !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 4000) begin
            errors++;
            $error("FAIL %s start_seen observed=%0d", tag, n);
        end
        if (exp_gap >= 0) begin
            checks++;
            if (n !== exp_gap) begin
                errors++;
                $error("FAIL %s gap observed=%0d expected=%0d", tag, n, exp_gap);
            end
        end
        for (int off = 0; off <= done_off + 1; off++) begin
            etx   = (off < nb*64) ? fb[off/64] : 1'b1;
            ebusy = (off <= done_off) ? 1'b1 : 1'b0;
            edone = (off == done_off) ? 1'b1 : 1'b0;
            checks++;
            if (tx_v[k] !== etx) begin
                errors++;
                $error("FAIL %s tx off=%0d observed=%0h expected=%0h", tag, off, tx_v[k], etx);
            end
            checks++;
            if (busy_v[k] !== ebusy) begin
                errors++;
                $error("FAIL %s busy off=%0d observed=%0h expected=%0h", tag, off, busy_v[k], ebusy);
            end
            checks++;
            if (done_v[k] !== edone) begin
                errors++;
                $error("FAIL %s done off=%0d observed=%0h expected=%0h", tag, off, done_v[k], edone);
            end
            if (off < done_off + 1) @(negedge clk);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w [12];
        int         lows;
        int         pulses;
        w = '{8'h01, 8'h80, 8'hA5, 8'h5A, 8'hFF, 8'h00, 8'h3C, 8'hC3, 8'h12, 8'h34, 8'hE7, 8'h7E};
        for (int i = 0; i < 6; i++) din_v[i] = 9'd0;
        valid_v = 6'd0;
        rst     = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (tx_v !== 6'h3F) begin errors++; $error("FAIL rst tx observed=%0h", tx_v); end
        checks++;
        if (busy_v !== 6'h00) begin errors++; $error("FAIL rst busy observed=%0h", busy_v); end
        checks++;
        if (done_v !== 6'h00) begin errors++; $error("FAIL rst done observed=%0h", done_v); end
        checks++;
        if (rdy_v !== 6'h3F) begin errors++; $error("FAIL rst ready observed=%0h", rdy_v); end
        checks++;
        if (cnt_v[0] !== 4'd0) begin errors++; $error("FAIL rst count observed=%0h", cnt_v[0]); end
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Basic frame 0x55
        push(0, 9'h055);
        checks++;
        if (cnt_v[0] !== 4'd1) begin errors++; $error("FAIL t1 count_after_push observed=%0h", cnt_v[0]); end
        frame(0, 9'h055, 8, 0, 1'b0, 16, 2, "t1");
        checks++;
        if (cnt_v[0] !== 4'd0) begin errors++; $error("FAIL t1 count_end observed=%0h", cnt_v[0]); end

        // Even / odd parity of 0x07
        push(1, 9'h007);
        frame(1, 9'h007, 8, 1, 1'b1, 16, 2, "t2_even");
        push(2, 9'h007);
        frame(2, 9'h007, 8, 1, 1'b0, 16, 2, "t2_odd");

        // Two and one-and-a-half stop bits
        push(3, 9'h0A3);
        frame(3, 9'h0A3, 8, 0, 1'b0, 32, 2, "t3_sb32");
        push(4, 9'h0A3);
        frame(4, 9'h0A3, 8, 0, 1'b0, 24, 2, "t3_sb24");

        // Streaming 12 words into an 8-deep FIFO
        fork
            begin
                int acc;
                int n;
                bit seen_full;
                acc = 0;
                seen_full = 1'b0;
                for (int i = 0; i < 12; i++) begin
                    din_v[0]   = {1'b0, w[i]};
                    valid_v[0] = 1'b1;
                    n = 0;
                    while (!rdy_v[0] && n < 5000) begin
                        if (!seen_full) begin
                            seen_full = 1'b1;
                            checks++;
                            if (acc !== 9) begin
                                errors++;
                                $error("FAIL t4 accepted_before_full observed=%0d", acc);
                            end
                            checks++;
                            if (cnt_v[0] !== 4'd8) begin
                                errors++;
                                $error("FAIL t4 count_full observed=%0h", cnt_v[0]);
                            end
                        end
                        @(negedge clk);
                        n++;
                    end
                    @(negedge clk);
                    acc++;
                end
                valid_v[0] = 1'b0;
                checks++;
                if (seen_full !== 1'b1) begin errors++; $error("FAIL t4 saw_full"); end
            end
            begin
                for (int j = 0; j < 12; j++) begin
                    frame(0, {1'b0, w[j]}, 8, 0, 1'b0, 16, (j == 0) ? -1 : 2, "t4");
                end
            end
        join
        checks++;
        if (cnt_v[0] !== 4'd0) begin errors++; $error("FAIL t4 count_end observed=%0h", cnt_v[0]); end

        // Reset mid-DATA with two words queued
        push(0, 9'h03C);
        push(0, 9'h011);
        push(0, 9'h022);
        repeat (84) @(negedge clk);
        checks++;
        if (tx_v[0] !== 1'b0) begin errors++; $error("FAIL t5 pre_tx observed=%0h", tx_v[0]); end
        checks++;
        if (busy_v[0] !== 1'b1) begin errors++; $error("FAIL t5 pre_busy observed=%0h", busy_v[0]); end
        checks++;
        if (cnt_v[0] !== 4'd2) begin errors++; $error("FAIL t5 pre_count observed=%0h", cnt_v[0]); end
        rst = 1'b1;
        #1;
        checks++;
        if (tx_v[0] !== 1'b1) begin errors++; $error("FAIL t5 rst_tx observed=%0h", tx_v[0]); end
        checks++;
        if (busy_v[0] !== 1'b0) begin errors++; $error("FAIL t5 rst_busy observed=%0h", busy_v[0]); end
        checks++;
        if (cnt_v[0] !== 4'd0) begin errors++; $error("FAIL t5 rst_count observed=%0h", cnt_v[0]); end
        @(negedge clk);
        rst = 1'b0;
        lows = 0;
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            if (tx_v[0] !== 1'b1) lows++;
            if (done_v[0] !== 1'b0) pulses++;
            @(negedge clk);
        end
        checks++;
        if (lows !== 0) begin errors++; $error("FAIL t5 line_idle observed=%0d", lows); end
        checks++;
        if (pulses !== 0) begin errors++; $error("FAIL t5 no_done observed=%0d", pulses); end
        push(0, 9'h081);
        frame(0, 9'h081, 8, 0, 1'b0, 16, 2, "t5_after");

        // 5-bit word from idle
        push(5, 9'h01F);
        frame(5, 9'h01F, 5, 0, 1'b0, 16, 2, "t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
